// File: rtl/hps_frame_sequencer.sv
// Purpose: sequence one still-frame capture and serve its pixels to the HPS over a 4-phase REQ/ACK handshake.
// Latency: ACK rises on the 4th iCLK edge after REQ is first sampled high, and falls on the 3rd edge after REQ is sampled low.
// Backpressure: the HPS paces every pixel; one read strobe is issued per handshake, however long REQ is held.
module hps_frame_sequencer #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int SKIP_FRAMES    = 2,
  parameter int LOAD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iHPS_START,
  input  logic        iHPS_REQ,
  input  logic [31:0] iFRAME_CONT,
  input  logic [15:0] iRD_DATA,
  output logic        oCAP_START,
  output logic        oCAP_END,
  output logic        oRD_LOAD,
  output logic        oRD_REQ,
  output logic [7:0]  oPIX_DATA,
  output logic        oHPS_ACK,
  output logic [9:0]  oROW,
  output logic [9:0]  oCOL,
  output logic [2:0]  oSTATE,
  output logic        oDONE,
  output logic        oERR
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_CAPTURE  = 3'd2,
    S_LOAD     = 3'd3,
    S_REQ_WAIT = 3'd4,
    S_FETCH    = 3'd5,
    S_ACK_HOLD = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES - 1);
  localparam logic [9:0]    COL_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    ROW_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [31:0]   SKIP_W     = 32'(SKIP_FRAMES);

  state_t          state_q, state_d;
  logic            start_s1_q, start_s1_d;
  logic            start_s2_q, start_s2_d;
  logic            start_prev_q, start_prev_d;
  logic            req_s1_q, req_s1_d;
  logic            req_s2_q, req_s2_d;
  logic [31:0]     f0_q, f0_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   load_cnt_q, load_cnt_d;
  logic            cap_start_q, cap_start_d;
  logic            cap_end_q, cap_end_d;
  logic            rd_load_q, rd_load_d;
  logic            rd_req_q, rd_req_d;
  logic [7:0]      pix_q, pix_d;
  logic            ack_q, ack_d;
  logic [9:0]      row_q, row_d;
  logic [9:0]      col_q, col_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            start_edge;
  logic            abort;
  logic [31:0]     frame_delta;
  logic            frame_stored;
  logic            last_pixel;

  // The upper byte of the read port carries nothing we serve.
  logic            unused_rd_hi;
  assign unused_rd_hi = ^iRD_DATA[15:8];

  assign start_edge   = start_s2_q & ~start_prev_q;
  assign abort        = ~start_s2_q;
  // Modular difference keeps the check correct across the 32-bit counter wrap.
  assign frame_delta  = iFRAME_CONT - f0_q;
  assign frame_stored = (frame_delta >= SKIP_W);
  assign last_pixel   = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state and registered-output decisions for the whole transaction.
  always_comb begin
    state_d      = state_q;
    start_s1_d   = iHPS_START;
    start_s2_d   = start_s1_q;
    start_prev_d = start_s2_q;
    req_s1_d     = iHPS_REQ;
    req_s2_d     = req_s1_q;
    f0_d         = f0_q;
    timer_d      = timer_q;
    load_cnt_d   = load_cnt_q;
    cap_start_d  = 1'b0;
    cap_end_d    = 1'b0;
    rd_load_d    = rd_load_q;
    rd_req_d     = 1'b0;
    pix_d        = pix_q;
    ack_d        = ack_q;
    row_d        = row_q;
    col_d        = col_q;
    done_d       = done_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_ARM;
          cap_start_d = 1'b1;
          err_d       = 1'b0;
        end
      end

      S_ARM: begin
        if (abort) begin
          state_d   = S_IDLE;
          cap_end_d = 1'b1;
        end else begin
          state_d = S_CAPTURE;
          f0_d    = iFRAME_CONT;
          timer_d = '0;
        end
      end

      S_CAPTURE: begin
        if (abort) begin
          state_d   = S_IDLE;
          cap_end_d = 1'b1;
        end else if (frame_stored) begin
          state_d    = S_LOAD;
          cap_end_d  = 1'b1;
          rd_load_d  = 1'b1;
          load_cnt_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = S_IDLE;
          cap_end_d = 1'b1;
          err_d     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          rd_load_d = 1'b0;
          row_d     = '0;
          col_d     = '0;
        end else if (load_cnt_q == LOAD_LAST) begin
          state_d   = S_REQ_WAIT;
          rd_load_d = 1'b0;
          row_d     = '0;
          col_d     = '0;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end

      S_REQ_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else if (req_s2_q) begin
          state_d  = S_FETCH;
          rd_req_d = 1'b1;
        end
      end

      S_FETCH: begin
        if (abort) begin
          state_d = S_IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          // Byte is captured on the way into ACK_HOLD and held until the next fetch.
          state_d = S_ACK_HOLD;
          pix_d   = iRD_DATA[7:0];
          ack_d   = 1'b1;
        end
      end

      S_ACK_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
          row_d   = '0;
          col_d   = '0;
        end else if (!req_s2_q) begin
          ack_d = 1'b0;
          if (last_pixel) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ_WAIT;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        ack_d = 1'b0;
        if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, synchronisers and every output register; synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      req_s1_q     <= 1'b0;
      req_s2_q     <= 1'b0;
      f0_q         <= '0;
      timer_q      <= '0;
      load_cnt_q   <= '0;
      cap_start_q  <= 1'b0;
      cap_end_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      rd_req_q     <= 1'b0;
      pix_q        <= '0;
      ack_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_s1_q   <= start_s1_d;
      start_s2_q   <= start_s2_d;
      start_prev_q <= start_prev_d;
      req_s1_q     <= req_s1_d;
      req_s2_q     <= req_s2_d;
      f0_q         <= f0_d;
      timer_q      <= timer_d;
      load_cnt_q   <= load_cnt_d;
      cap_start_q  <= cap_start_d;
      cap_end_q    <= cap_end_d;
      rd_load_q    <= rd_load_d;
      rd_req_q     <= rd_req_d;
      pix_q        <= pix_d;
      ack_q        <= ack_d;
      row_q        <= row_d;
      col_q        <= col_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign oCAP_START = cap_start_q;
  assign oCAP_END   = cap_end_q;
  assign oRD_LOAD   = rd_load_q;
  assign oRD_REQ    = rd_req_q;
  assign oPIX_DATA  = pix_q;
  assign oHPS_ACK   = ack_q;
  assign oROW       = row_q;
  assign oCOL       = col_q;
  assign oSTATE     = state_q;
  assign oDONE      = done_q;
  assign oERR       = err_q;

endmodule

// File: tb/tb_hps_frame_sequencer.sv
// Purpose: self-checking bench for hps_frame_sequencer on a 4x2 frame with a 100-cycle capture timeout.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled there and on the falling edge.
// Backpressure: the bench plays the HPS, pacing each pixel handshake itself.
module tb_hps_frame_sequencer;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        req;
  logic [31:0] frame;
  logic [15:0] rd;
  logic        oCAP_START, oCAP_END, oRD_LOAD, oRD_REQ, oHPS_ACK, oDONE, oERR;
  logic [7:0]  oPIX_DATA;
  logic [9:0]  oROW, oCOL;
  logic [2:0]  oSTATE;

  int n_pass  = 0;
  int n_total = 0;

  // Model: index of the pixel the HPS is currently being served; its byte, row and column follow from it.
  int pix_idx = 0;
  int cap_start_cnt = 0;
  int cap_end_cnt   = 0;
  int rd_load_cnt   = 0;
  int rd_req_cnt    = 0;

  hps_frame_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2), .LOAD_CYCLES(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iHPS_START(start), .iHPS_REQ(req),
    .iFRAME_CONT(frame), .iRD_DATA(rd),
    .oCAP_START(oCAP_START), .oCAP_END(oCAP_END), .oRD_LOAD(oRD_LOAD), .oRD_REQ(oRD_REQ),
    .oPIX_DATA(oPIX_DATA), .oHPS_ACK(oHPS_ACK), .oROW(oROW), .oCOL(oCOL),
    .oSTATE(oSTATE), .oDONE(oDONE), .oERR(oERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (oSTATE !== s && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, oSTATE, s);
  endtask

  task automatic wait_ack(input logic v, output int k);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (oHPS_ACK !== v && k < 20);
  endtask

  // One full 4-phase handshake for pixel pix_idx, optionally holding REQ high for extra cycles.
  task automatic handshake(input int hold, input bit pin, input logic [7:0] pd,
                           input logic [9:0] pr, input logic [9:0] pc);
    int k;
    int rq0;
    rd  = 16'h5500 | 16'(8'(8'hA0 + pix_idx));
    rq0 = rd_req_cnt;
    req = 1'b1;
    wait_ack(1'b1, k);
    chk("ack_rise_latency", k, 4);
    rd = 16'hFFFF;
    if (pin) begin
      chk("pin_pix", oPIX_DATA, pd);
      chk("pin_row", oROW, pr);
      chk("pin_col", oCOL, pc);
    end
    if (hold > 0) begin
      tick(hold);
      chk("ack_held", oHPS_ACK, 1);
      chk("col_held", oCOL, 10'(pix_idx % H));
    end
    chk("one_rd_req", rd_req_cnt - rq0, 1);
    req = 1'b0;
    wait_ack(1'b0, k);
    chk("ack_fall_latency", k, 3);
    chk("post_hs_state", oSTATE, (pix_idx == NPIX - 1) ? 3'd7 : 3'd4);
    pix_idx++;
  endtask

  // Per-cycle compare against the model, plus pulse counters.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (oCAP_START === 1'b1) cap_start_cnt++;
      if (oCAP_END === 1'b1)   cap_end_cnt++;
      if (oRD_LOAD === 1'b1)   rd_load_cnt++;
      if (oRD_REQ === 1'b1)    rd_req_cnt++;
      if (oCAP_START === 1'b1 || oCAP_END === 1'b1)
        chk("cap_exclusive", 32'(oCAP_START & oCAP_END), 0);
      if (oRD_LOAD === 1'b1) chk("rd_load_in_load", oSTATE, 3);
      if (oHPS_ACK === 1'b1) begin
        chk("ack_pix", oPIX_DATA, 8'(8'hA0 + pix_idx));
        chk("ack_row", oROW, 10'(pix_idx / H));
        chk("ack_col", oCOL, 10'(pix_idx % H));
        chk("ack_state", oSTATE, 6);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    int base_cs, base_ce, base_ld, base_rq;

    rst_n = 1'b0; start = 1'b0; req = 1'b0; frame = '0; rd = '0;
    tick(3);
    chk("rst_state", oSTATE, 0);
    chk("rst_ctl", {oCAP_START, oCAP_END, oRD_LOAD, oRD_REQ, oHPS_ACK, oDONE, oERR}, 0);
    chk("rst_pix", oPIX_DATA, 0);
    chk("rst_pos", {oROW, oCOL}, 0);
    rst_n = 1'b1;
    tick(5);
    chk("idle_after_rst", oSTATE, 0);

    // Small frame: full transaction.
    frame = 32'd100;
    base_cs = cap_start_cnt; base_ld = rd_load_cnt; base_rq = rd_req_cnt;
    start = 1'b1;
    wait_state(3'd2, 20, "enter_capture");
    chk("cap_start_once", cap_start_cnt - base_cs, 1);
    chk("err_clear", oERR, 0);
    frame = 32'd101;
    tick(2);
    chk("capture_one_frame", oSTATE, 2);
    frame = 32'd102;
    tick(1);
    chk("capture_exit", oSTATE, 3);
    chk("cap_end_pulse", oCAP_END, 1);
    tick(1);
    chk("cap_end_one_cycle", oCAP_END, 0);
    wait_state(3'd4, 20, "enter_req_wait");
    chk("load_cycles", rd_load_cnt - base_ld, 8);
    pix_idx = 0;
    for (int n = 0; n < NPIX; n++) begin
      if (n == 0)      handshake(0, 1'b1, 8'hA0, 10'd0, 10'd0);
      else if (n == 7) handshake(0, 1'b1, 8'hA7, 10'd1, 10'd3);
      else             handshake(0, 1'b0, 8'h00, 10'd0, 10'd0);
    end
    chk("done_state", oSTATE, 7);
    chk("done_flag", oDONE, 1);
    chk("rd_req_total", rd_req_cnt - base_rq, 8);
    start = 1'b0;
    wait_state(3'd0, 20, "done_to_idle");
    chk("done_cleared", oDONE, 0);

    // Frame counter wrap across 0xFFFFFFFF.
    tick(3);
    frame = 32'hFFFF_FFFF;
    base_ce = cap_end_cnt;
    start = 1'b1;
    wait_state(3'd2, 20, "wrap_capture");
    frame = 32'h0000_0000;
    tick(1);
    chk("wrap_step0", oSTATE, 2);
    frame = 32'h0000_0001;
    tick(1);
    chk("wrap_exit", oSTATE, 3);
    start = 1'b0;
    wait_state(3'd0, 20, "load_abort");
    chk("load_abort_rd_load", oRD_LOAD, 0);
    tick(1);
    chk("cap_end_count_wrap", cap_end_cnt - base_ce, 1);

    // REQ held high, then abort mid-frame and restart.
    tick(3);
    frame = 32'd5;
    start = 1'b1;
    wait_state(3'd2, 20, "hold_capture");
    frame = 32'd7;
    wait_state(3'd4, 30, "hold_req_wait");
    pix_idx = 0;
    handshake(0, 1'b0, 8'h00, 10'd0, 10'd0);
    handshake(20, 1'b1, 8'hA1, 10'd0, 10'd1);
    rd  = 16'h00A2;
    req = 1'b1;
    wait_ack(1'b1, k);
    chk("p2_ack", oHPS_ACK, 1);
    chk("p2_pos", {oROW, oCOL}, {10'd0, 10'd2});
    start = 1'b0;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (oSTATE !== 3'd0 && k < 20);
    chk("abort_latency", k, 3);
    chk("abort_ack", oHPS_ACK, 0);
    chk("abort_pos", {oROW, oCOL}, 0);
    req = 1'b0;
    tick(3);
    frame = 32'd20;
    start = 1'b1;
    wait_state(3'd2, 20, "restart_capture");
    frame = 32'd22;
    wait_state(3'd4, 30, "restart_req_wait");
    pix_idx = 0;
    handshake(0, 1'b1, 8'hA0, 10'd0, 10'd0);
    start = 1'b0;
    wait_state(3'd0, 20, "restart_idle");

    // Capture timeout with a frozen frame counter.
    tick(3);
    frame = 32'h1234;
    start = 1'b1;
    wait_state(3'd2, 20, "timeout_capture");
    cnt = 0;
    while (oSTATE === 3'd2 && cnt < 400) begin
      cnt++;
      tick(1);
    end
    chk("timeout_cycles", cnt, 100);
    chk("timeout_idle", oSTATE, 0);
    chk("timeout_cap_end", oCAP_END, 1);
    chk("timeout_err", oERR, 1);
    tick(5);
    chk("err_sticky", oERR, 1);
    chk("no_rearm_without_edge", oSTATE, 0);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    wait_state(3'd2, 20, "rearm_capture");
    chk("err_cleared_on_arm", oERR, 0);

    // Reset mid-capture: back to IDLE with no capture-end pulse.
    rst_n = 1'b0;
    tick(1);
    chk("midrst_state", oSTATE, 0);
    chk("midrst_cap_end", oCAP_END, 0);
    chk("midrst_err", oERR, 0);
    rst_n = 1'b1;
    start = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
